// File: rtl/present_masked_player_collect_pkg.sv
// Shared constants, types and the PRESENT bit permutation index for the
// masked pLayer collector.
package present_masked_player_collect_pkg;

    localparam int unsigned PRESENT_NIBBLES = 16;
    localparam int unsigned PRESENT_STATE_W = 64;

    typedef struct packed {
        logic [PRESENT_STATE_W-1:0] s1;
        logic [PRESENT_STATE_W-1:0] s0;
    } share_pair_t;

    // Destination of state bit i under the PRESENT pLayer.
    function automatic int unsigned player_idx(input int unsigned i);
        return (i == 63) ? 32'd63 : (i * 16) % 63;
    endfunction

endpackage

// File: rtl/present_masked_player_collect_if.sv
// Issue/capture/output handshake bundle between sbox side, collector and the next round stage.
interface present_masked_player_collect_if;

    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  y_s0;
    logic [3:0]  y_s1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] state_s0;
    logic [63:0] state_s1;

    modport master (
        output issue_valid, y_s0, y_s1, out_ready,
        input  issue_ready, out_valid, state_s0, state_s1
    );

    modport slave (
        input  issue_valid, y_s0, y_s1, out_ready,
        output issue_ready, out_valid, state_s0, state_s1
    );

endinterface

// File: rtl/present_masked_player_collect_player.sv
// PRESENT pLayer as pure wiring; one instance per share so the shares never meet.
module present_player
    import present_masked_player_collect_pkg::*;
(
    input  logic [PRESENT_STATE_W-1:0] data_i,
    output logic [PRESENT_STATE_W-1:0] data_o
);

    for (genvar i = 0; i < PRESENT_STATE_W; i++) begin : g_bit
        assign data_o[player_idx(i)] = data_i[i];
    end

endmodule

// File: rtl/present_masked_player_collect.sv
// Collects 16 masked sbox output nibbles per round into two share registers,
// applies pLayer per share and presents the pair over a valid/ready handshake.
module present_masked_player_collect
    import present_masked_player_collect_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 3,
    parameter int unsigned NIBBLES  = PRESENT_NIBBLES
) (
    input logic                             clk,
    input logic                             ap_rst,
    present_masked_player_collect_if.slave  bus
);

    localparam int unsigned CntW  = $clog2(NIBBLES + 1);
    localparam int unsigned SlotW = $clog2(NIBBLES);

    logic [SBOX_LAT-1:0] pipe_q, pipe_d;
    logic [CntW-1:0]     icnt_q, icnt_d;
    logic [CntW-1:0]     ccnt_q, ccnt_d;
    share_pair_t         col_q, col_d;
    share_pair_t         state_q, state_d;
    logic                out_valid_q, out_valid_d;

    logic                issue_fire;
    logic                cap;
    logic                full;
    logic                xfer;
    logic [SlotW+1:0]    bit_base;
    logic [PRESENT_STATE_W-1:0] perm_s0;
    logic [PRESENT_STATE_W-1:0] perm_s1;

    // icnt counts in-flight plus captured nibbles, so the pipe can never overrun the collector.
    assign bus.issue_ready = (icnt_q < CntW'(NIBBLES));
    assign issue_fire      = bus.issue_valid & bus.issue_ready;
    assign cap             = pipe_q[SBOX_LAT-1];
    assign full            = (ccnt_q == CntW'(NIBBLES));
    assign xfer            = full & (~out_valid_q | bus.out_ready);
    assign bit_base        = {ccnt_q[SlotW-1:0], 2'b00};

    present_player u_player_s0 (
        .data_i (col_q.s0),
        .data_o (perm_s0)
    );

    present_player u_player_s1 (
        .data_i (col_q.s1),
        .data_o (perm_s1)
    );

    always_comb begin
        pipe_d = (pipe_q << 1) | SBOX_LAT'(issue_fire);

        icnt_d = icnt_q;
        if (xfer) begin
            icnt_d = '0;
        end else if (issue_fire) begin
            icnt_d = icnt_q + 1'b1;
        end

        ccnt_d = ccnt_q;
        col_d  = col_q;
        if (xfer) begin
            ccnt_d = '0;
        end else if (cap) begin
            ccnt_d = ccnt_q + 1'b1;
            col_d.s0[bit_base +: 4] = bus.y_s0;
            col_d.s1[bit_base +: 4] = bus.y_s1;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            state_d.s0  = perm_s0;
            state_d.s1  = perm_s1;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            pipe_q      <= '0;
            icnt_q      <= '0;
            ccnt_q      <= '0;
            col_q       <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pipe_q      <= pipe_d;
            icnt_q      <= icnt_d;
            ccnt_q      <= ccnt_d;
            col_q       <= col_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.state_s0  = state_q.s0;
    assign bus.state_s1  = state_q.s1;

endmodule

// File: tb/tb_present_masked_player_collect.sv
// Scoreboard bench: a delay-line sbox model feeds the collector, expected blocks are
// queued at issue time and compared when the collector hands them over.
module tb_present_masked_player_collect;
    import present_masked_player_collect_pkg::*;

    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic ap_rst;
    always #5 clk = ~clk;

    present_masked_player_collect_if bus_if ();

    present_masked_player_collect #(
        .SBOX_LAT (LAT),
        .NIBBLES  (16)
    ) dut (
        .clk    (clk),
        .ap_rst (ap_rst),
        .bus    (bus_if)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    int          n_out    = 0;
    logic [7:0]  sb_q [LAT];
    share_pair_t exp_q [$];
    logic [63:0] acc0, acc1;
    int          acc_n;
    bit          use_lit;
    logic [63:0] lit0, lit1;
    int          first_edge, last_edge;

    function automatic logic [63:0] player_model(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[(i == 63) ? 63 : (i * 16) % 63] = x[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive, score any output handshake, advance the sbox model.
    task automatic cycle(input bit iv, input logic [3:0] d0, input logic [3:0] d1,
                         input bit ordy);
        logic        fire;
        share_pair_t e;
        bus_if.issue_valid = iv;
        bus_if.out_ready   = ordy;
        #1;
        fire = iv & bus_if.issue_ready;
        if (bus_if.out_valid && ordy) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_s0", bus_if.state_s0, e.s0);
                check("out_s1", bus_if.state_s1, e.s1);
            end
            n_out++;
        end
        if (fire) begin
            acc0[4*acc_n +: 4] = d0;
            acc1[4*acc_n +: 4] = d1;
            acc_n++;
            if (acc_n == 16) begin
                e.s0 = use_lit ? lit0 : player_model(acc0);
                e.s1 = use_lit ? lit1 : player_model(acc1);
                exp_q.push_back(e);
                acc_n = 0;
                acc0  = '0;
                acc1  = '0;
            end
        end
        @(posedge clk);
        edge_n++;
        for (int i = LAT - 1; i > 0; i--) sb_q[i] = sb_q[i-1];
        sb_q[0] = fire ? {d1, d0} : 8'($urandom);
        #1;
        bus_if.y_s0 = sb_q[LAT-1][3:0];
        bus_if.y_s1 = sb_q[LAT-1][7:4];
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        cycle(1'b0, 4'h0, 4'h0, 1'b0);
        ap_rst = 1'b0;
        acc_n  = 0;
        acc0   = '0;
        acc1   = '0;
        exp_q.delete();
    endtask

    task automatic run_block(input logic [63:0] b0, input logic [63:0] b1, input bit sparse,
                             input bit ordy);
        int k = 0;
        int guard = 0;
        while (k < 16 && guard < 400) begin
            guard++;
            if (bus_if.issue_ready) begin
                cycle(1'b1, b0[4*k +: 4], b1[4*k +: 4], ordy);
                if (k == 0) first_edge = edge_n;
                last_edge = edge_n;
                k++;
                if (sparse) cycle(1'b0, 4'h0, 4'h0, ordy);
            end else begin
                cycle(1'b0, 4'h0, 4'h0, ordy);
            end
        end
        check("issue_budget", 64'(k), 64'd16);
    endtask

    task automatic wait_out();
        int g = 0;
        while (!bus_if.out_valid && g < 60) begin
            cycle(1'b0, 4'h0, 4'h0, 1'b0);
            g++;
        end
        check("out_valid_seen", 64'(bus_if.out_valid), 64'd1);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 80) begin
            cycle(1'b0, 4'h0, 4'h0, 1'b1);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_ov_low", 64'(bus_if.out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] r0, r1;
        int          outs_before;
        for (int i = 0; i < LAT; i++) sb_q[i] = '0;
        ap_rst             = 1'b1;
        bus_if.issue_valid = 1'b0;
        bus_if.out_ready   = 1'b0;
        bus_if.y_s0        = '0;
        bus_if.y_s1        = '0;
        use_lit            = 1'b0;
        lit0               = '0;
        lit1               = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        check("rst_state_s0", bus_if.state_s0, 64'd0);
        check("rst_state_s1", bus_if.state_s1, 64'd0);

        // Single-bit mapping and first-output latency.
        use_lit = 1'b1;
        lit0    = 64'h0001_0000_0000_0000;
        lit1    = 64'h0;
        run_block(64'h8, 64'h0, 1'b0, 1'b0);
        wait_out();
        check("latency_first", 64'(edge_n - first_edge), 64'd19);
        drain();

        // Full-nibble spread.
        lit0 = 64'h0001_0001_0001_0001;
        lit1 = 64'h0001_0000_0001_0000;
        run_block(64'hF, 64'hA, 1'b0, 1'b1);
        drain();

        // Fixed point bit 63 and endpoint 60 -> 15.
        lit0 = 64'h8000_0000_0000_0000;
        lit1 = 64'h0000_0000_0000_8000;
        run_block(64'h8000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1'b1);
        drain();

        // Backpressure: block 1 held while block 2 fills the collector.
        use_lit = 1'b0;
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};
        run_block(r0, r1, 1'b0, 1'b0);
        wait_out();
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        check("bp_issue_ready_low", 64'(bus_if.issue_ready), 64'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 4'h0, 1'b0);
        check("bp_hold_valid", 64'(bus_if.out_valid), 64'd1);
        check("bp_hold_s0", bus_if.state_s0, exp_q[0].s0);
        check("bp_hold_s1", bus_if.state_s1, exp_q[0].s1);
        check("bp_queue_two", 64'(exp_q.size()), 64'd2);
        cycle(1'b0, 4'h0, 4'h0, 1'b1);
        check("bp_next_valid", 64'(bus_if.out_valid), 64'd1);
        check("bp_issue_ready_high", 64'(bus_if.issue_ready), 64'd1);
        drain();

        // Same block back-to-back and sparse; sparse output one cycle after last capture.
        run_block(r0, r1, 1'b0, 1'b1);
        drain();
        run_block(r0, r1, 1'b1, 1'b0);
        wait_out();
        check("sparse_latency", 64'(edge_n - last_edge), 64'(LAT + 1));
        drain();

        // Reset mid-block discards partial and in-flight nibbles.
        for (int i = 0; i < 7; i++) cycle(1'b1, 4'($urandom), 4'($urandom), 1'b0);
        do_reset();
        check("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("midrst_issue_ready", 64'(bus_if.issue_ready), 64'd1);
        outs_before = n_out;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
        check("midrst_one_block", 64'(n_out - outs_before), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
